// File: rtl/imm_gen_pipe.sv
// Registered RV32I/RV64I immediate generator with a 2-entry skid FIFO between IF/ID and ID/EX.
// Decode is combinational on the incoming word; every output comes from FIFO storage.
module imm_gen_pipe #(
  parameter int XLEN = 32,
  parameter int RV64 = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);
  localparam logic [2:0] F_NONE = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3,
                         F_U = 3'd4, F_J = 3'd5, F_SH = 3'd6;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            ill;
  } ent_t;

  ent_t       dec;
  ent_t       mem [2];
  logic [1:0] count;
  logic       rd_ptr, wr_ptr;
  logic       push, pop;
  logic [6:0] opc;
  logic [2:0] f3;
  logic       is_sh;
  logic [5:0] shamt;

  assign opc   = in_instr[6:0];
  assign f3    = in_instr[14:12];
  assign is_sh = (f3 == 3'b001) || (f3 == 3'b101);
  // 6-bit shamt only for the 64-bit OP-IMM shifts; the *W forms stay 5-bit.
  assign shamt = (RV64 != 0 && opc == 7'b0010011) ? in_instr[25:20] : {1'b0, in_instr[24:20]};

  always_comb begin
    dec = '0;
    case (opc)
      7'b0000011, 7'b1100111: begin
        dec.imm = XLEN'($signed(in_instr[31:20]));
        dec.fmt = F_I;
      end
      7'b0010011: begin
        dec.imm = is_sh ? XLEN'(shamt) : XLEN'($signed(in_instr[31:20]));
        dec.fmt = is_sh ? F_SH : F_I;
      end
      7'b0011011: begin
        if (RV64 != 0) begin
          dec.imm = is_sh ? XLEN'(shamt) : XLEN'($signed(in_instr[31:20]));
          dec.fmt = is_sh ? F_SH : F_I;
        end else begin
          dec.ill = 1'b1;
        end
      end
      7'b0100011: begin
        dec.imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
        dec.fmt = F_S;
      end
      7'b1100011: begin
        dec.imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
        dec.fmt = F_B;
      end
      7'b0110111, 7'b0010111: begin
        dec.imm = XLEN'($signed({in_instr[31:12], 12'b0}));
        dec.fmt = F_U;
      end
      7'b1101111: begin
        dec.imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
        dec.fmt = F_J;
      end
      default: begin
        dec.fmt = F_NONE;
        dec.ill = 1'b1;
      end
    endcase
  end

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) mem[i] <= '0;
    end else if (flush) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: ;
      endcase
    end
  end

  assign out_imm     = mem[rd_ptr].imm;
  assign out_fmt     = mem[rd_ptr].fmt;
  assign out_illegal = mem[rd_ptr].ill;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: RV32 instance for decode/FIFO/flush/reset, RV64 instance for 6-bit shamt.
module tb_imm_gen_pipe;
  logic        clk, rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic        rdy32, vld32, ill32, rdy64, vld64, ill64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [2:0]  fmt32, fmt64;
  int          nchk, nerr;

  imm_gen_pipe #(.XLEN(32), .RV64(0)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .out_valid(vld32), .out_ready(out_ready), .out_imm(imm32),
    .out_fmt(fmt32), .out_illegal(ill32));

  imm_gen_pipe #(.XLEN(64), .RV64(1)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .out_valid(vld64), .out_ready(out_ready), .out_imm(imm64),
    .out_fmt(fmt64), .out_illegal(ill64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nchk = 0; nerr = 0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = 32'h0;
    #3;
    chk("rst_vld", vld32, 0);
    chk("rst_rdy", rdy32, 1);
    chk("rst_imm", imm32, 0);
    chk("rst_fmt", fmt32, 0);
    chk("rst_ill", ill32, 0);
    #9 rst_n = 1'b1;
    step();

    // addi x1,x0,-1
    in_valid = 1; out_ready = 1; in_instr = 32'hFFF00093;
    step();
    chk("addi_vld", vld32, 1);
    chk("addi_imm", imm32, 32'hFFFFFFFF);
    chk("addi_fmt", fmt32, 1);
    chk("addi_ill", ill32, 0);
    chk("addi64_imm", imm64, 64'hFFFFFFFFFFFFFFFF);

    // beq -4 then jal +8 back-to-back
    in_instr = 32'hFE000EE3;
    step();
    chk("beq_imm", imm32, 32'hFFFFFFFC);
    chk("beq_fmt", fmt32, 3);
    chk("beq64_imm", imm64, 64'hFFFFFFFFFFFFFFFC);
    in_instr = 32'h0080006F;
    step();
    chk("jal_vld", vld32, 1);
    chk("jal_imm", imm32, 32'h8);
    chk("jal_fmt", fmt32, 5);

    // srai, lui, add
    in_instr = 32'h4030D093;
    step();
    chk("srai_imm", imm32, 3);
    chk("srai_fmt", fmt32, 6);
    in_instr = 32'h123450B7;
    step();
    chk("lui_imm", imm32, 32'h12345000);
    chk("lui_fmt", fmt32, 4);
    in_instr = 32'h00000033;
    step();
    chk("add_ill", ill32, 1);
    chk("add_imm", imm32, 0);
    chk("add_fmt", fmt32, 0);

    // slli 63: 5-bit shamt on RV32, 6-bit on RV64
    in_instr = 32'h03F09093;
    step();
    chk("slli32_imm", imm32, 31);
    chk("slli64_imm", imm64, 63);
    chk("slli64_fmt", fmt64, 6);
    in_valid = 0;
    step();
    chk("drain_vld", vld32, 0);

    // backpressure: three words, only two fit
    out_ready = 0; in_valid = 1; in_instr = 32'h00500093;
    step();
    chk("bp1_vld", vld32, 1);
    chk("bp1_rdy", rdy32, 1);
    chk("bp1_imm", imm32, 5);
    in_instr = 32'h0020A223;
    step();
    chk("bp2_rdy", rdy32, 0);
    chk("bp2_imm", imm32, 5);
    in_instr = 32'hABCDE0B7;
    step();
    chk("bp3_rdy", rdy32, 0);
    chk("bp3_hold", imm32, 5);
    chk("bp3_hfmt", fmt32, 1);
    out_ready = 1;
    step();
    chk("bp4_imm", imm32, 4);
    chk("bp4_fmt", fmt32, 2);
    chk("bp4_rdy", rdy32, 1);
    step();
    chk("bp5_imm", imm32, 32'hABCDE000);
    chk("bp5_fmt", fmt32, 4);
    in_valid = 0;
    step();
    chk("bp6_vld", vld32, 0);

    // flush while full, with a same-cycle input
    out_ready = 0; in_valid = 1; in_instr = 32'h00500093;
    step();
    in_instr = 32'h0020A223;
    step();
    chk("fl_full", rdy32, 0);
    flush = 1; in_instr = 32'h123450B7;
    step();
    chk("fl_vld", vld32, 0);
    chk("fl_rdy", rdy32, 1);
    flush = 0; in_valid = 0; out_ready = 1;
    step();
    chk("fl_gone", vld32, 0);

    // flush with one entry and an accepted-looking input
    out_ready = 0; in_valid = 1; in_instr = 32'h00500093;
    step();
    flush = 1; in_instr = 32'h0080006F;
    step();
    flush = 0; in_valid = 0;
    chk("fl1_vld", vld32, 0);
    step();
    chk("fl1_gone", vld32, 0);

    // async reset mid-stream
    in_valid = 1; in_instr = 32'hFFF00093;
    step();
    in_valid = 0;
    chk("ar_pre", vld32, 1);
    #2 rst_n = 0;
    #1;
    chk("ar_vld", vld32, 0);
    chk("ar_imm", imm32, 0);
    chk("ar_rdy", rdy32, 1);
    #3 rst_n = 1;
    step();
    chk("ar_post", vld32, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
